mant_mul_arbiter: RTL and testbench



---
 rtl/mant_mul_pkg.sv | 14 +
 rtl/mant_mul_arbiter_rr_arb2.sv | 34 +++
 rtl/mant_mul_arbiter.sv | 102 ++++++++++
 tb/tb_mant_mul_arbiter.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mant_mul_pkg.sv
// Shared types and widths for the mantissa multiplier arbiter slice.
package mant_mul_pkg;

    localparam int MANT_W = 24;
    localparam int PROD_W = 2 * MANT_W;

    typedef logic req_id_t;

    typedef struct packed {
        logic    valid;
        req_id_t id;
    } tag_t;

endpackage

// File: rtl/mant_mul_arbiter_rr_arb2.sv
// Two-requester round-robin grant with its pointer register.
module rr_arb2
    import mant_mul_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] gnt,
    output logic       any_gnt,
    output req_id_t    gnt_id
);

    logic rr_q;

    always_comb begin
        gnt_id  = (req == 2'b11) ? rr_q : (req == 2'b10);
        any_gnt = en & (|req);
        gnt     = 2'b00;
        if (any_gnt) begin
            gnt = gnt_id ? 2'b10 : 2'b01;
        end
    end

    // After any grant the pointer favours the requester that lost or was absent.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_q <= 1'b0;
        end else if (any_gnt) begin
            rr_q <= ~gnt_id;
        end
    end

endmodule

// File: rtl/mant_mul_arbiter.sv
// Shares one pipelined mantissa multiplier between two requesters and
// routes each product back to its owner via a tag pipeline.
module mant_mul_arbiter
    import mant_mul_pkg::*;
#(
    parameter int W       = MANT_W,
    parameter int LATENCY = 3
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         req0_valid,
    output logic                         req0_ready,
    input  logic [W-1:0]                 req0_a,
    input  logic [W-1:0]                 req0_b,
    input  logic                         req1_valid,
    output logic                         req1_ready,
    input  logic [W-1:0]                 req1_a,
    input  logic [W-1:0]                 req1_b,
    input  logic                         stall,
    input  logic                         flush,
    output logic [W-1:0]                 mul_a,
    output logic [W-1:0]                 mul_b,
    output logic                         mul_en,
    input  logic [2*W-1:0]               mul_p,
    output logic                         res0_valid,
    output logic                         res1_valid,
    output logic [2*W-1:0]               res_p,
    output logic                         busy,
    output logic [$clog2(LATENCY+1)-1:0] inflight
);

    localparam int IW = $clog2(LATENCY + 1);

    logic                 adv;
    logic                 live_q;
    logic [1:0]           gnt;
    logic                 any_gnt;
    req_id_t              gnt_id;
    tag_t [LATENCY-1:0]   tag_q;
    logic [LATENCY-1:0]   v;
    logic [IW-1:0]        cnt;

    assign adv    = ~stall;
    assign mul_en = adv;

    // Held low from reset assertion until the first edge after release, so
    // no ready is offered while the block is in reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            live_q <= 1'b0;
        end else begin
            live_q <= 1'b1;
        end
    end

    rr_arb2 u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (adv & ~flush & live_q),
        .req     ({req1_valid, req0_valid}),
        .gnt     (gnt),
        .any_gnt (any_gnt),
        .gnt_id  (gnt_id)
    );

    assign req0_ready = gnt[0];
    assign req1_ready = gnt[1];
    assign mul_a      = gnt[1] ? req1_a : req0_a;
    assign mul_b      = gnt[1] ? req1_b : req0_b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_q <= '0;
        end else if (flush) begin
            tag_q <= '0;
        end else if (adv) begin
            tag_q[0] <= '{valid: any_gnt, id: gnt_id};
            for (int k = 1; k < LATENCY; k++) begin
                tag_q[k] <= tag_q[k-1];
            end
        end
    end

    always_comb begin
        cnt = '0;
        v   = '0;
        for (int k = 0; k < LATENCY; k++) begin
            v[k] = tag_q[k].valid;
            cnt  = cnt + IW'(tag_q[k].valid);
        end
    end

    assign busy     = |v;
    assign inflight = cnt;

    // Gating with adv means a stalled result is presented exactly once, on
    // the cycle the pipeline finally moves it out.
    assign res0_valid = tag_q[LATENCY-1].valid && (tag_q[LATENCY-1].id == 1'b0) && adv && !flush;
    assign res1_valid = tag_q[LATENCY-1].valid && (tag_q[LATENCY-1].id == 1'b1) && adv && !flush;
    assign res_p      = mul_p;

endmodule

// File: tb/tb_mant_mul_arbiter.sv
// Directed bench for mant_mul_arbiter at LATENCY=3 and LATENCY=1.
module tb_mant_mul_arbiter;
    import mant_mul_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        req0_valid, req1_valid;
    logic [23:0] req0_a, req0_b, req1_a, req1_b;
    logic        stall, flush;

    logic        rdy0_3, rdy1_3, en_3, res0_3, res1_3, busy_3;
    logic [23:0] ma_3, mb_3;
    logic [47:0] mp_3, rp_3;
    logic [1:0]  infl_3;

    logic        rdy0_1, rdy1_1, en_1, res0_1, res1_1, busy_1;
    logic [23:0] ma_1, mb_1;
    logic [47:0] mp_1, rp_1;
    logic [0:0]  infl_1;

    mant_mul_arbiter #(.W(24), .LATENCY(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(rdy0_3), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(rdy1_3), .req1_a(req1_a), .req1_b(req1_b),
        .stall(stall), .flush(flush),
        .mul_a(ma_3), .mul_b(mb_3), .mul_en(en_3), .mul_p(mp_3),
        .res0_valid(res0_3), .res1_valid(res1_3), .res_p(rp_3),
        .busy(busy_3), .inflight(infl_3)
    );

    mant_mul_arbiter #(.W(24), .LATENCY(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(rdy0_1), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(rdy1_1), .req1_a(req1_a), .req1_b(req1_b),
        .stall(stall), .flush(flush),
        .mul_a(ma_1), .mul_b(mb_1), .mul_en(en_1), .mul_p(mp_1),
        .res0_valid(res0_1), .res1_valid(res1_1), .res_p(rp_1),
        .busy(busy_1), .inflight(infl_1)
    );

    // Behavioural multiplier pipelines driven by the arbiter's enable.
    logic [47:0] m3 [3];
    logic [47:0] m1;
    always_ff @(posedge clk) begin
        if (en_3) begin
            m3[0] <= {24'b0, ma_3} * {24'b0, mb_3};
            m3[1] <= m3[0];
            m3[2] <= m3[1];
        end
        if (en_1) begin
            m1 <= {24'b0, ma_1} * {24'b0, mb_1};
        end
    end
    assign mp_3 = m3[2];
    assign mp_1 = m1;

    int n_tests = 0;
    int n_fail  = 0;
    int n_pulse = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic smp;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
        req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
        stall = 1'b0; flush = 1'b0;

        // reset state
        #1;
        smp;
        chk("rst_rdy0", 64'(rdy0_3), 64'd0);
        chk("rst_rdy1", 64'(rdy1_3), 64'd0);
        chk("rst_res0", 64'(res0_3), 64'd0);
        chk("rst_res1", 64'(res1_3), 64'd0);
        chk("rst_busy", 64'(busy_3), 64'd0);
        chk("rst_infl", 64'(infl_3), 64'd0);
        tick;
        rst_n = 1'b1;
        tick;
        tick;

        // contention: strict alternation starting at requester 0
        req0_a = 24'd2; req0_b = 24'd3; req1_a = 24'd7; req1_b = 24'd11;
        for (int c = 0; c < 9; c++) begin
            req0_valid = (c < 6);
            req1_valid = (c < 6);
            smp;
            chk("cont_rdy0", 64'(rdy0_3), 64'(c < 6 && c % 2 == 0));
            chk("cont_rdy1", 64'(rdy1_3), 64'(c < 6 && c % 2 == 1));
            if (c >= 3) begin
                chk("cont_res0", 64'(res0_3), 64'((c - 3) % 2 == 0));
                chk("cont_res1", 64'(res1_3), 64'((c - 3) % 2 == 1));
                chk("cont_resp", 64'(rp_3), ((c - 3) % 2 == 0) ? 64'd6 : 64'd77);
            end
            tick;
        end
        req0_valid = 1'b0; req1_valid = 1'b0;

        // single requester
        req0_a = 24'h800000; req0_b = 24'hC00000;
        for (int c = 0; c < 5; c++) begin
            req0_valid = (c == 0);
            smp;
            chk("single_rdy0", 64'(rdy0_3), 64'(c == 0));
            chk("single_rdy1", 64'(rdy1_3), 64'd0);
            chk("single_res0", 64'(res0_3), 64'(c == 3));
            chk("single_res1", 64'(res1_3), 64'd0);
            if (c == 3) chk("single_resp", 64'(rp_3), 64'h6000_0000_0000);
            tick;
        end
        req0_valid = 1'b0;

        // stall: op0 issued at 0, stalled 1..2, req1 waits through the stall
        req0_a = 24'd5; req0_b = 24'd6; req1_a = 24'd9; req1_b = 24'd9;
        for (int c = 0; c < 8; c++) begin
            req0_valid = (c == 0);
            req1_valid = (c >= 1 && c <= 3);
            stall      = (c == 1 || c == 2);
            smp;
            chk("stall_rdy0", 64'(rdy0_3), 64'(c == 0));
            chk("stall_rdy1", 64'(rdy1_3), 64'(c == 3));
            chk("stall_res0", 64'(res0_3), 64'(c == 5));
            chk("stall_res1", 64'(res1_3), 64'(c == 6));
            if (c == 5) chk("stall_resp0", 64'(rp_3), 64'd30);
            if (c == 6) chk("stall_resp1", 64'(rp_3), 64'd81);
            if (c >= 1 && c <= 3) chk("stall_infl", 64'(infl_3), 64'd1);
            if (c == 1) chk("stall_mul_en", 64'(en_3), 64'd0);
            tick;
        end
        req0_valid = 1'b0; req1_valid = 1'b0; stall = 1'b0;

        // flush with two ops in flight and a request in the flush cycle
        req0_a = 24'd1; req0_b = 24'd1; req1_a = 24'd2; req1_b = 24'd2;
        for (int c = 0; c < 7; c++) begin
            req0_valid = (c == 0 || c == 2);
            req1_valid = (c == 1);
            flush      = (c == 2);
            smp;
            chk("flush_rdy0", 64'(rdy0_3), 64'(c == 0));
            chk("flush_rdy1", 64'(rdy1_3), 64'(c == 1));
            chk("flush_res0", 64'(res0_3), 64'd0);
            chk("flush_res1", 64'(res1_3), 64'd0);
            if (c == 2) begin
                chk("flush_busy_pre", 64'(busy_3), 64'd1);
                chk("flush_infl_pre", 64'(infl_3), 64'd2);
            end
            if (c >= 3) begin
                chk("flush_busy", 64'(busy_3), 64'd0);
                chk("flush_infl", 64'(infl_3), 64'd0);
            end
            tick;
        end
        req0_valid = 1'b0; req1_valid = 1'b0; flush = 1'b0;

        // async reset with three ops in flight
        req0_a = 24'd3; req0_b = 24'd4; req1_a = 24'd5; req1_b = 24'd6;
        req0_valid = 1'b1; req1_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            smp;
            chk("arst_burst_rdy0", 64'(rdy0_3), 64'(c % 2 == 0));
            tick;
        end
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_rdy0", 64'(rdy0_3), 64'd0);
        chk("arst_rdy1", 64'(rdy1_3), 64'd0);
        chk("arst_res0", 64'(res0_3), 64'd0);
        chk("arst_res1", 64'(res1_3), 64'd0);
        chk("arst_busy", 64'(busy_3), 64'd0);
        chk("arst_infl", 64'(infl_3), 64'd0);
        tick;
        tick;
        req0_valid = 1'b0; req1_valid = 1'b0;
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            smp;
            chk("arst_stale_res0", 64'(res0_3), 64'd0);
            chk("arst_stale_res1", 64'(res1_3), 64'd0);
            chk("arst_stale_busy", 64'(busy_3), 64'd0);
            tick;
        end
        req0_valid = 1'b1; req1_valid = 1'b1;
        smp;
        chk("arst_first_rdy0", 64'(rdy0_3), 64'd1);
        chk("arst_first_rdy1", 64'(rdy1_3), 64'd0);
        tick;
        req0_valid = 1'b0; req1_valid = 1'b0;
        for (int c = 1; c < 5; c++) begin
            smp;
            chk("arst_new_res0", 64'(res0_3), 64'(c == 3));
            chk("arst_new_res1", 64'(res1_3), 64'd0);
            if (c == 3) chk("arst_new_resp", 64'(rp_3), 64'd12);
            tick;
        end

        // LATENCY=1 back-to-back, alternating owners
        for (int c = 0; c < 22; c++) begin
            req0_valid = (c < 20) && (c % 2 == 0);
            req1_valid = (c < 20) && (c % 2 == 1);
            req0_a = 24'(c + 1); req0_b = 24'(c + 2);
            req1_a = 24'(c + 1); req1_b = 24'(c + 2);
            smp;
            if (c < 20) begin
                chk("lat1_rdy0", 64'(rdy0_1), 64'(c % 2 == 0));
                chk("lat1_rdy1", 64'(rdy1_1), 64'(c % 2 == 1));
            end
            if (c >= 1 && c <= 20) begin
                chk("lat1_res0", 64'(res0_1), 64'((c - 1) % 2 == 0));
                chk("lat1_res1", 64'(res1_1), 64'((c - 1) % 2 == 1));
                chk("lat1_resp", 64'(rp_1), 64'(c * (c + 1)));
            end
            if (c == 21) begin
                chk("lat1_tail_res0", 64'(res0_1), 64'd0);
                chk("lat1_tail_res1", 64'(res1_1), 64'd0);
            end
            if (res0_1 || res1_1) n_pulse++;
            tick;
        end
        chk("lat1_pulse_count", 64'(n_pulse), 64'd20);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
